// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing helpers for the FIFO read-side stream adapter.
package fifo_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_skid_buf.sv
// Small circular prefetch buffer with push/pop/clear; supports non-power-of-2 depths.
module fifo_stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    input  logic                          clear,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [count_w(BUF_DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = count_w(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage carries no reset; an empty buffer presents zero instead.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: prefetches words and re-presents them as a
// valid/ready stream, hiding the FIFO's one-cycle read latency.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          fifo_re,
    input  logic [DATA_WIDTH-1:0]         fifo_r_data,
    input  logic                          fifo_empty,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          flush,
    output logic                          flush_busy,
    output logic [count_w(BUF_DEPTH)-1:0] buf_count
);

    localparam int CNT_W = count_w(BUF_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

    state_t         state;
    logic           inflight;
    logic           clear;
    logic           push;
    logic           pop;
    logic           credit_ok;
    logic [CNT_W:0] occupancy;

    // Credit counts the word still in flight so a returning word always has a slot.
    assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = occupancy < DEPTH_C;

    assign fifo_re    = (state == ST_RUN) && !flush && !fifo_empty && credit_ok;
    assign m_valid    = (state == ST_RUN) && (buf_count != '0);
    assign flush_busy = (state == ST_FLUSH);

    // A flush request wins over both a returning word and a same-cycle consumer pop.
    assign clear = flush || (state == ST_FLUSH);
    assign push  = inflight && !clear;
    assign pop   = m_valid && m_ready && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_re;
            case (state)
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!inflight && !flush) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    fifo_stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(fifo_r_data),
        .pop      (pop),
        .clear    (clear),
        .rd_data  (m_data),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural 8x8 synchronous FIFO feeding fifo_stream_reader.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_re;
    logic [7:0] fifo_r_data;
    logic       fifo_empty;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       flush = 1'b0;
    logic       flush_busy;
    logic [1:0] buf_count;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_re    (fifo_re),
        .fifo_r_data(fifo_r_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .flush_busy (flush_busy),
        .buf_count  (buf_count)
    );

    // Behavioural 8x8 FIFO: registered read data one cycle after an accepted read.
    logic [7:0] fmem [8];
    logic [2:0] fw, fr;
    logic [3:0] fcnt;
    logic       do_rd, do_wr;
    int         re_pulses = 0;
    int         cyc = 0;

    assign fifo_empty = (fcnt == 4'd0);
    assign do_rd = fifo_re && !fifo_empty;
    assign do_wr = wr_en && (fcnt != 4'd8);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fw <= '0; fr <= '0; fcnt <= '0; fifo_r_data <= '0;
        end else begin
            if (do_wr) begin fmem[fw] <= wr_data; fw <= fw + 3'd1; end
            if (do_rd) begin fifo_r_data <= fmem[fr]; fr <= fr + 3'd1; end
            fcnt <= fcnt + {3'd0, do_wr} - {3'd0, do_rd};
            if (fifo_re) re_pulses <= re_pulses + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: delivered words, stall stability, underrun and occupancy tracking.
    logic [7:0] got [$];
    int         dcyc [$];
    int         underrun = 0, stall_err = 0, stalls = 0, maxcnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            if (fifo_re && fifo_empty) underrun++;
            if (int'(buf_count) > maxcnt) maxcnt = int'(buf_count);
            if (prev_stall && (!m_valid || m_data != prev_data)) stall_err++;
            if (m_valid && m_ready && !flush) begin
                got.push_back(m_data);
                dcyc.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready && !flush;
            if (prev_stall) stalls++;
            prev_data = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_stream(input string tag, input int base, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD, 32'(exp[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_words(input logic [7:0] w[$], output int t0);
        t0 = 0;
        for (int i = 0; i < w.size(); i++) begin
            wr_en = 1'b1;
            wr_data = w[i];
            tick();
            if (i == 0) t0 = cyc;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w1 [$];
        logic [7:0] w8 [$];
        logic [7:0] wexp [$];
        int t0, base, re_base, gaps, errs;

        // Reset state
        idle(2);
        @(negedge clk);
        check("rst_fifo_re", 32'(fifo_re), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_flush_busy", 32'(flush_busy), 0);
        check("rst_buf_count", 32'(buf_count), 0);
        tick();
        rst = 1'b1;
        idle(2);

        // 1: three words, latency and no gaps
        m_ready = 1'b1;
        w1 = '{8'h24, 8'h81, 8'h09};
        base = got.size();
        write_words(w1, t0);
        idle(10);
        check_stream("t1", base, w1);
        check("t1_latency", 32'(dcyc[base] - t0), 2);
        check("t1_gap01", 32'(dcyc[base + 1] - dcyc[base]), 1);
        check("t1_gap12", 32'(dcyc[base + 2] - dcyc[base + 1]), 1);
        check("t1_idle_valid", 32'(m_valid), 0);

        // 2: eight words back to back
        w8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base = got.size();
        write_words(w8, t0);
        idle(12);
        check_stream("t2", base, w8);
        gaps = 0;
        for (int i = 1; i < 8; i++)
            if (base + i < dcyc.size() && dcyc[base + i] - dcyc[base + i - 1] != 1) gaps++;
        check("t2_gaps", 32'(gaps), 0);

        // 3: consumer stalled, prefetch stops at buffer depth
        m_ready = 1'b0;
        w8 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        base = got.size();
        re_base = re_pulses;
        write_words(w8, t0);
        idle(12);
        @(negedge clk);
        check("t3_re_pulses", 32'(re_pulses - re_base), 3);
        check("t3_buf_count", 32'(buf_count), 3);
        check("t3_m_valid", 32'(m_valid), 1);
        check("t3_m_data", 32'(m_data), 32'hC0);
        tick();
        m_ready = 1'b1;
        idle(20);
        check_stream("t3", base, w8);

        // 4: m_ready toggling 1010...
        w8 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        base = got.size();
        for (int i = 0; i < 40; i++) begin
            wr_en = (i < 8);
            wr_data = (i < 8) ? w8[i] : 8'h00;
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b1;
        idle(6);
        check_stream("t4", base, w8);
        check("t4_stall_seen", 32'(stalls > 0), 1);
        check("t4_stall_stable", 32'(stall_err), 0);

        // 5: one-cycle flush while streaming; w2 and w3 are discarded
        w8 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
        base = got.size();
        for (int i = 0; i < 26; i++) begin
            tick();
            wr_en = (i < 8);
            wr_data = (i < 8) ? w8[i] : 8'h00;
            flush = (i == 5);
            m_ready = 1'b1;
            @(negedge clk);
            if (i == 5) begin
                check("t5_pre_valid", 32'(m_valid), 1);
                check("t5_pre_busy", 32'(flush_busy), 0);
            end
            if (i == 6) begin
                check("t5_valid", 32'(m_valid), 0);
                check("t5_busy", 32'(flush_busy), 1);
                check("t5_count", 32'(buf_count), 0);
            end
            if (i == 7) check("t5_busy_done", 32'(flush_busy), 0);
        end
        tick();
        wr_en = 1'b0;
        flush = 1'b0;
        wexp = '{8'h50, 8'h51, 8'h54, 8'h55, 8'h56, 8'h57};
        idle(4);
        check_stream("t5", base, wexp);

        // 6: asynchronous reset mid-stream
        w8 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = w8[i];
            tick();
        end
        @(negedge clk);
        check("t6_pre_valid", 32'(m_valid), 1);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_fifo_re", 32'(fifo_re), 0);
        check("t6_m_valid", 32'(m_valid), 0);
        check("t6_m_data", 32'(m_data), 0);
        check("t6_flush_busy", 32'(flush_busy), 0);
        check("t6_buf_count", 32'(buf_count), 0);
        #11;
        rst = 1'b1;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_re || m_valid) errs++;
        end
        check("t6_post_quiet", 32'(errs), 0);

        check("no_underrun", 32'(underrun), 0);
        check("max_count_le_depth", 32'(maxcnt <= 3), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
